clock_set_ctrl: RTL



---
 rtl/clock_pkg.sv | 20 ++
 rtl/clock_set_ctrl_btn_pulse.sv | 26 ++
 rtl/clock_set_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// Shared definitions for the HH:MM clock controller: FSM state codes,
// BCD digit limits, colon position and per-digit blank masks.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2
  } state_t;

  localparam logic [3:0] MIN_ONES_MAX = 4'd9;
  localparam logic [3:0] MIN_TENS_MAX = 4'd5;
  // Hour limit held in BCD so it compares directly against {h1,h0}
  localparam logic [7:0] HOUR_MAX     = 8'h23;

  localparam logic [3:0] POINTS_COLON = 4'b0100;
  localparam logic [3:0] LES_HOURS    = 4'b1100;
  localparam logic [3:0] LES_MINS     = 4'b0011;

endpackage

// File: rtl/clock_set_ctrl_btn_pulse.sv
// Button conditioner: 2-flop synchroniser followed by a registered
// rising-edge detect, giving one press pulse 3 clocks after the level rises.
module btn_pulse (
  input  logic clk,
  input  logic RST,
  input  logic btn,
  output logic pulse
);

  logic sync_p0, sync_p1, prev_p2;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      prev_p2 <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
      pulse   <= sync_p1 & ~prev_p2;
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// HH:MM time-keeping and time-setting controller: BCD minute advance on the
// timebase, mode FSM for setting hours/minutes, and blinking digit blanks.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int TICKS_PER_STEP = 1,
  parameter int BLINK_TICKS    = 3
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        tick,
  input  logic        btn_mode,
  input  logic        btn_inc,
  output logic [15:0] HEXS,
  output logic [3:0]  points,
  output logic [3:0]  LES,
  output logic [1:0]  mode
);

  localparam logic [15:0] STEP_LAST  = 16'(TICKS_PER_STEP - 1);
  localparam logic [7:0]  BLINK_LAST = 8'(BLINK_TICKS - 1);

  state_t      state, state_nx;
  logic        mode_p, inc_p, state_chg;
  logic [15:0] step_cnt, step_cnt_nx;
  logic [7:0]  blink_cnt, blink_cnt_nx;
  logic        blink_ph, blink_ph_nx;
  logic [15:0] hexs_nx;
  logic [3:0]  les_nx;
  logic [8:0]  min_sum;

  // Returns {wrapped_from_59, next_minutes}
  function automatic logic [8:0] min_inc(input logic [7:0] mm);
    if (mm[3:0] == MIN_ONES_MAX) begin
      if (mm[7:4] == MIN_TENS_MAX) return {1'b1, 8'h00};
      return {1'b0, mm[7:4] + 4'd1, 4'd0};
    end
    return {1'b0, mm[7:4], mm[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] hour_inc(input logic [7:0] hh);
    if (hh == HOUR_MAX) return 8'h00;
    if (hh[3:0] == 4'd9) return {hh[7:4] + 4'd1, 4'd0};
    return {hh[7:4], hh[3:0] + 4'd1};
  endfunction

  btn_pulse u_mode_btn (.clk(clk), .RST(RST), .btn(btn_mode), .pulse(mode_p));
  btn_pulse u_inc_btn  (.clk(clk), .RST(RST), .btn(btn_inc),  .pulse(inc_p));

  always_ff @(posedge clk or posedge RST) begin
    if (RST) state <= RUN;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      RUN:     if (mode_p) state_nx = SET_H;
      SET_H:   if (mode_p) state_nx = SET_M;
      SET_M:   if (mode_p) state_nx = RUN;
      default: state_nx = RUN;
    endcase
  end

  assign state_chg = (state_nx != state);

  always_comb begin
    min_sum      = min_inc(HEXS[7:0]);
    hexs_nx      = HEXS;
    step_cnt_nx  = 16'd0;
    blink_cnt_nx = blink_cnt;
    blink_ph_nx  = blink_ph;
    les_nx       = 4'b0000;
    case (state)
      RUN: begin
        step_cnt_nx = step_cnt;
        if (tick) begin
          if (step_cnt == STEP_LAST) begin
            step_cnt_nx = 16'd0;
            hexs_nx = {min_sum[8] ? hour_inc(HEXS[15:8]) : HEXS[15:8], min_sum[7:0]};
          end else begin
            step_cnt_nx = step_cnt + 16'd1;
          end
        end
      end
      // A mode press in the same cycle swallows the inc press
      SET_H: if (inc_p && !mode_p) hexs_nx[15:8] = hour_inc(HEXS[15:8]);
      SET_M: if (inc_p && !mode_p) hexs_nx[7:0]  = min_sum[7:0];
      default: ;
    endcase
    if (state_chg) step_cnt_nx = 16'd0;

    // Blink restarts visible on every state change and is idle in RUN
    if (state_chg || state_nx == RUN) begin
      blink_cnt_nx = 8'd0;
      blink_ph_nx  = 1'b0;
    end else if (tick) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt_nx = 8'd0;
        blink_ph_nx  = ~blink_ph;
      end else begin
        blink_cnt_nx = blink_cnt + 8'd1;
      end
    end
    if (blink_ph_nx) begin
      if (state_nx == SET_H)      les_nx = LES_HOURS;
      else if (state_nx == SET_M) les_nx = LES_MINS;
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      HEXS      <= 16'h0000;
      step_cnt  <= 16'd0;
      blink_cnt <= 8'd0;
      blink_ph  <= 1'b0;
      LES       <= 4'b0000;
    end else begin
      HEXS      <= hexs_nx;
      step_cnt  <= step_cnt_nx;
      blink_cnt <= blink_cnt_nx;
      blink_ph  <= blink_ph_nx;
      LES       <= les_nx;
    end
  end

  assign mode   = state;
  assign points = POINTS_COLON;

endmodule
